// File: rtl/conv_pkg.sv
// Shared width helpers and the output activation/saturation function for the
// multi-channel convolution kernel.
package conv_pkg;

  function automatic int dot_w(input int wi, input int n);
    return 2 * (wi + 1) + $clog2(n);
  endfunction

  function automatic int acc_w(input int wi, input int n, input int max_chunks);
    return dot_w(wi, n) + $clog2(max_chunks);
  endfunction

  // The bias term may be shifted up by 31, so it can outgrow the product term.
  function automatic int post_w(input int aw, input int pb);
    return ((aw + pb > pb + 31) ? aw + pb : pb + 31) + 1;
  endfunction

  function automatic logic signed [63:0] relu_sat(input logic signed [63:0] v,
                                                  input int bits,
                                                  input logic last_layer);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    if (last_layer) begin
      hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (bits - 1));
    end else begin
      hi = (64'sd1 <<< bits) - 64'sd1;
      lo = '0;
    end
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
    return r;
  endfunction

endpackage

// File: rtl/conv_dot_n.sv
// N-lane unsigned-activation x signed-weight multiply followed by an adder tree;
// products and sum are each registered once.
module conv_dot_n
  import conv_pkg::*;
#(
  parameter int N  = 16,
  parameter int WI = 8
) (
  input  logic                              clk,
  input  logic                              en_p0,
  input  logic                              en_p1,
  input  logic [N*WI-1:0]                   din,
  input  logic [N*WI-1:0]                   win,
  output logic signed [dot_w(WI, N)-1:0]    dot_p1
);

  localparam int PW = 2 * (WI + 1);
  localparam int DW = dot_w(WI, N);

  logic signed [PW-1:0] prod_p0 [N];
  logic signed [DW-1:0] sum;

  // stage p0: lane products
  always_ff @(posedge clk) begin
    if (en_p0) begin
      for (int i = 0; i < N; i++) begin
        prod_p0[i] <= PW'($signed({1'b0, din[i*WI +: WI]})) * PW'($signed(win[i*WI +: WI]));
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + DW'(prod_p0[i]);
    end
  end

  // stage p1: lane sum
  always_ff @(posedge clk) begin
    if (en_p1) dot_p1 <= sum;
  end

endmodule

// File: rtl/conv_kern_mc.sv
// Multi-channel convolution kernel: per-pixel chunked dot-product accumulation,
// scale/bias/shift post-processing, activation, and a credit-limited output FIFO.
module conv_kern_mc
  import conv_pkg::*;
#(
  parameter int N          = 16,
  parameter int M          = 4,
  parameter int WI         = 8,
  parameter int ACT_BITS   = 8,
  parameter int PARAM_BITS = 16,
  parameter int MAX_CHUNKS = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [$clog2(MAX_CHUNKS):0]    cfg_chunks,
  input  logic                           is_last_layer,
  input  logic [2:0]                     act_shift,
  input  logic [4:0]                     bias_shift,
  input  logic [M*PARAM_BITS-1:0]        scale,
  input  logic [M*PARAM_BITS-1:0]        bias,
  input  logic                           vld_i,
  output logic                           rdy_o,
  input  logic [N*WI-1:0]                din,
  input  logic [M*N*WI-1:0]              win,
  output logic                           vld_o,
  input  logic                           rdy_i,
  output logic [M*ACT_BITS-1:0]          acc_o
);

  localparam int CW  = $clog2(MAX_CHUNKS) + 1;
  localparam int DW  = dot_w(WI, N);
  localparam int AW  = acc_w(WI, N, MAX_CHUNKS);
  localparam int TW  = post_w(AW, PARAM_BITS);
  localparam int PTW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  logic          accept, first_beat, last_beat, done_acc, pop, push;
  logic [CW-1:0] cnt, c_lat, c_eff, c_cur;

  assign accept = vld_i && rdy_o;

  always_comb begin
    if (cfg_chunks == '0)                   c_eff = CW'(1);
    else if (cfg_chunks > CW'(MAX_CHUNKS))  c_eff = CW'(MAX_CHUNKS);
    else                                    c_eff = cfg_chunks;
    c_cur      = (cnt == '0) ? c_eff : c_lat;
    first_beat = (cnt == '0);
    last_beat  = (cnt == c_cur - CW'(1));
  end

  assign done_acc = accept && last_beat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      c_lat <= '0;
    end else if (accept) begin
      if (first_beat) c_lat <= c_eff;
      cnt <= last_beat ? '0 : cnt + CW'(1);
    end
  end

  // stages p0/p1: dot products per output channel
  logic signed [DW-1:0] dot_p1 [M];
  logic vld_p0, first_p0, last_p0, vld_p1, first_p1, last_p1, vld_p2, vld_p3, vld_p4;

  for (genvar m = 0; m < M; m++) begin : g_dot
    conv_dot_n #(.N(N), .WI(WI)) u_dot (
      .clk    (clk),
      .en_p0  (accept),
      .en_p1  (vld_p0),
      .din    (din),
      .win    (win[m*N*WI +: N*WI]),
      .dot_p1 (dot_p1[m])
    );
  end

  logic [M*PARAM_BITS-1:0] scale_p0, scale_p1, scale_p2, bias_p0, bias_p1, bias_p2;
  logic [4:0]              bs_p0, bs_p1, bs_p2;
  logic [2:0]              as_p0, as_p1, as_p2;
  logic                    ll_p0, ll_p1, ll_p2, ll_p3;

  always_ff @(posedge clk) begin
    if (accept) begin
      scale_p0 <= scale;
      bias_p0  <= bias;
      bs_p0    <= bias_shift;
      as_p0    <= act_shift;
      ll_p0    <= is_last_layer;
    end
    if (vld_p0) begin
      scale_p1 <= scale_p0;
      bias_p1  <= bias_p0;
      bs_p1    <= bs_p0;
      as_p1    <= as_p0;
      ll_p1    <= ll_p0;
    end
    if (vld_p1) begin
      scale_p2 <= scale_p1;
      bias_p2  <= bias_p1;
      bs_p2    <= bs_p1;
      as_p2    <= as_p1;
      ll_p2    <= ll_p1;
    end
  end

  // stage p2: accumulation; only a completed pixel moves further
  logic signed [AW-1:0] acc_p2 [M];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      last_p0  <= 1'b0;
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      vld_p2   <= 1'b0;
      vld_p3   <= 1'b0;
      vld_p4   <= 1'b0;
      for (int m = 0; m < M; m++) acc_p2[m] <= '0;
    end else begin
      vld_p0   <= accept;
      first_p0 <= accept && first_beat;
      last_p0  <= done_acc;
      vld_p1   <= vld_p0;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
      vld_p2   <= vld_p1 && last_p1;
      vld_p3   <= vld_p2;
      vld_p4   <= vld_p3;
      if (vld_p1) begin
        for (int m = 0; m < M; m++)
          acc_p2[m] <= first_p1 ? AW'(dot_p1[m]) : acc_p2[m] + AW'(dot_p1[m]);
      end
    end
  end

  // stage p3: scale and bias
  logic signed [TW-1:0] t_p3 [M];
  logic [5:0]           sh_p3;

  always_ff @(posedge clk) begin
    if (vld_p2) begin
      for (int m = 0; m < M; m++)
        t_p3[m] <= TW'(acc_p2[m]) * TW'($signed(scale_p2[m*PARAM_BITS +: PARAM_BITS]))
                 + (TW'($signed(bias_p2[m*PARAM_BITS +: PARAM_BITS])) <<< bs_p2);
      sh_p3 <= {1'b0, bs_p2} + {3'b000, as_p2};
      ll_p3 <= ll_p2;
    end
  end

  // stage p4: floor shift and activation
  logic signed [TW-1:0]  t_shr [M];
  logic [M*ACT_BITS-1:0] y_nxt, y_p4;

  always_comb begin
    y_nxt = '0;
    for (int m = 0; m < M; m++) begin
      t_shr[m] = t_p3[m] >>> sh_p3;
      y_nxt[m*ACT_BITS +: ACT_BITS] = ACT_BITS'(relu_sat(64'(t_shr[m]), ACT_BITS, ll_p3));
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p3) y_p4 <= y_nxt;
  end

  // Output FIFO; pend reserves a slot for every pixel from completion to pop.
  logic [M*ACT_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTW-1:0]        wr_ptr, rd_ptr;
  logic [FCW-1:0]        f_cnt, pend, pend_nxt;

  assign push  = vld_p4;
  assign vld_o = (f_cnt != '0);
  assign pop   = vld_o && rdy_i;
  assign acc_o = vld_o ? mem[rd_ptr] : '0;

  always_comb begin
    pend_nxt = pend;
    if (done_acc && !pop)      pend_nxt = pend + FCW'(1);
    else if (!done_acc && pop) pend_nxt = pend - FCW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= y_p4;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      f_cnt  <= '0;
      pend   <= '0;
      rdy_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTW'(1);
      case ({push, pop})
        2'b10:   f_cnt <= f_cnt + FCW'(1);
        2'b01:   f_cnt <= f_cnt - FCW'(1);
        default: f_cnt <= f_cnt;
      endcase
      pend  <= pend_nxt;
      rdy_o <= (pend_nxt < FCW'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_conv_kern_mc.sv
// Directed and randomized bench for conv_kern_mc with a per-pixel arithmetic model.
module tb_conv_kern_mc;

  localparam int N = 16, M = 4, WI = 8, AB = 8, PB = 16, MAXC = 16, FD = 4;

  logic              clk, rstn;
  logic [4:0]        cfg_chunks;
  logic              is_last_layer;
  logic [2:0]        act_shift;
  logic [4:0]        bias_shift;
  logic [M*PB-1:0]   scale, bias;
  logic              vld_i, rdy_o, vld_o, rdy_i;
  logic [N*WI-1:0]   din;
  logic [M*N*WI-1:0] win;
  logic [M*AB-1:0]   acc_o;

  int n_chk = 0, n_fail = 0;
  int mcnt = 0, mC = 1, sk = 0;
  longint macc [M];
  logic [M*AB-1:0] exp_q[$], got_q[$];
  logic [M*AB-1:0] tmp_w;

  conv_kern_mc #(.N(N), .M(M), .WI(WI), .ACT_BITS(AB), .PARAM_BITS(PB),
                 .MAX_CHUNKS(MAXC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rstn(rstn), .cfg_chunks(cfg_chunks), .is_last_layer(is_last_layer),
    .act_shift(act_shift), .bias_shift(bias_shift), .scale(scale), .bias(bias),
    .vld_i(vld_i), .rdy_o(rdy_o), .din(din), .win(win),
    .vld_o(vld_o), .rdy_i(rdy_i), .acc_o(acc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (rstn === 1'b1 && vld_o === 1'b1 && rdy_i === 1'b1) got_q.push_back(acc_o);

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [M*AB-1:0] post_model();
    logic [M*AB-1:0] r;
    longint sc, b, t, y, hi, lo;
    r = '0;
    for (int m = 0; m < M; m++) begin
      sc = longint'($signed(scale[m*PB +: PB]));
      b  = longint'($signed(bias[m*PB +: PB]));
      t  = macc[m] * sc + (b <<< int'(bias_shift));
      y  = t >>> (int'(bias_shift) + int'(act_shift));
      hi = is_last_layer ? (longint'(1) <<< (AB - 1)) - 1 : (longint'(1) <<< AB) - 1;
      lo = is_last_layer ? -(longint'(1) <<< (AB - 1)) : 0;
      if (y > hi) y = hi;
      if (y < lo) y = lo;
      r[m*AB +: AB] = y[AB-1:0];
    end
    return r;
  endfunction

  task automatic model_beat();
    int c;
    if (mcnt == 0) begin
      c = int'(cfg_chunks);
      if (c == 0) c = 1;
      if (c > MAXC) c = MAXC;
      mC = c;
      for (int m = 0; m < M; m++) macc[m] = 0;
    end
    for (int m = 0; m < M; m++)
      for (int i = 0; i < N; i++)
        macc[m] += longint'(din[i*WI +: WI]) * longint'($signed(win[(m*N+i)*WI +: WI]));
    mcnt++;
    if (mcnt == mC) begin
      exp_q.push_back(post_model());
      mcnt = 0;
    end
  endtask

  task automatic beat(input string tag);
    bit ok = 0;
    vld_i = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rdy_o) begin ok = 1; break; end
    end
    chk({tag, "_accept"}, 64'(ok), 64'd1);
    if (ok) model_beat();
    @(posedge clk); #1;
    vld_i = 1'b0;
  endtask

  task automatic lat_check(input string tag, input logic [AB-1:0] e);
    repeat (4) begin @(posedge clk); #1; end
    chk({tag, "_early"}, 64'(vld_o), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_vld"}, 64'(vld_o), 64'd1);
    chk({tag, "_ch0"}, 64'(acc_o[AB-1:0]), 64'(e));
  endtask

  task automatic drain_check(input string tag);
    logic [M*AB-1:0] e, g;
    int w = 0;
    rdy_i = 1'b1;
    while (got_q.size() < exp_q.size() && w < 200) begin @(posedge clk); #1; w++; end
    repeat (8) begin @(posedge clk); #1; end
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_data"}, 64'(g), 64'(e));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) din[i*WI +: WI] = ($urandom_range(0, 1) == 1) ? WI'($urandom) : '0;
    for (int j = 0; j < M*N; j++) win[j*WI +: WI] = WI'($urandom);
  endtask

  task automatic stream(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (vld_i && rdy_o) begin
        model_beat();
        sk++;
        @(posedge clk); #1;
        if (sk >= 6) vld_i = 1'b0;
        else rand_data();
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rstn = 1'b1; vld_i = 1'b0; rdy_i = 1'b1; din = '0; win = '0;
    cfg_chunks = 5'd1; is_last_layer = 1'b0; act_shift = '0; bias_shift = '0;
    scale = '0; bias = '0;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_vld_o", 64'(vld_o), 64'd0);
    chk("rst_rdy_o", 64'(rdy_o), 64'd0);
    chk("rst_acc_o", 64'(acc_o), 64'd0);
    rstn = 1'b1;
    #1 chk("rst_rdy_pre_edge", 64'(rdy_o), 64'd0);
    @(posedge clk); #1;
    chk("rst_rdy_after_edge", 64'(rdy_o), 64'd1);

    // single-beat pixel, positive result
    scale = {M{16'd256}}; bias = {M{16'd2}}; bias_shift = 5'd8; act_shift = 3'd0;
    din[7:0] = 8'd10; win[7:0] = 8'd3;
    beat("d30");
    lat_check("d30", 8'd32);
    drain_check("d30");

    // negative result under ReLU and under signed saturation
    win[7:0] = 8'hFD;
    beat("d31_relu");
    lat_check("d31_relu", 8'd0);
    is_last_layer = 1'b1;
    beat("d31_last");
    lat_check("d31_last", 8'hE4);
    drain_check("d31");

    // three-beat pixel
    is_last_layer = 1'b0; win[7:0] = 8'd3; bias = '0; cfg_chunks = 5'd3;
    beat("d32_b0"); beat("d32_b1"); beat("d32_b2");
    lat_check("d32", 8'd90);
    @(posedge clk); #1;
    chk("d32_single_pulse", 64'(vld_o), 64'd0);
    drain_check("d32");

    // full-scale saturation
    cfg_chunks = 5'd1; din = {N{8'hFF}}; win = {(M*N){8'h7F}};
    beat("d33_relu");
    lat_check("d33_relu", 8'd255);
    is_last_layer = 1'b1;
    beat("d33_last");
    lat_check("d33_last", 8'd127);
    drain_check("d33");

    // backpressure: six back-to-back pixels with the consumer stalled
    is_last_layer = 1'b0; rdy_i = 1'b0; sk = 0;
    rand_data(); vld_i = 1'b1;
    stream(20);
    chk("d34_accepted_stalled", 64'(sk), 64'd4);
    chk("d34_rdy_low", 64'(rdy_o), 64'd0);
    chk("d34_vld_high", 64'(vld_o), 64'd1);
    rdy_i = 1'b1;
    stream(60);
    chk("d34_accepted_all", 64'(sk), 64'd6);
    vld_i = 1'b0;
    drain_check("d34");

    // reset in the middle of a pixel with a result waiting in the FIFO
    rdy_i = 1'b0; cfg_chunks = 5'd1; rand_data();
    beat("d35_pre");
    repeat (6) begin @(posedge clk); #1; end
    chk("d35_fifo_loaded", 64'(vld_o), 64'd1);
    cfg_chunks = 5'd3;
    rand_data(); beat("d35_p0");
    rand_data(); beat("d35_p1");
    rstn = 1'b0;
    #1;
    chk("d35_rst_vld_o", 64'(vld_o), 64'd0);
    chk("d35_rst_rdy_o", 64'(rdy_o), 64'd0);
    chk("d35_rst_acc_o", 64'(acc_o), 64'd0);
    mcnt = 0; exp_q.delete(); got_q.delete();
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    chk("d35_rdy_back", 64'(rdy_o), 64'd1);
    rdy_i = 1'b1;
    rand_data(); beat("d35_f0");
    rand_data(); beat("d35_f1");
    rand_data(); beat("d35_f2");
    tmp_w = exp_q[$];
    lat_check("d35_fresh", tmp_w[AB-1:0]);
    drain_check("d35");

    // randomized pixels, including cfg_chunks==0 and mid-pixel cfg changes
    for (int p = 0; p < 40; p++) begin
      cfg_chunks = 5'($urandom_range(0, 4));
      for (int m = 0; m < M; m++) begin
        scale[m*PB +: PB] = PB'($urandom_range(0, 600)) - PB'(300);
        bias[m*PB +: PB]  = PB'($urandom_range(0, 200)) - PB'(100);
      end
      bias_shift = 5'($urandom_range(6, 14));
      act_shift = 3'($urandom_range(0, 7));
      is_last_layer = 1'($urandom_range(0, 1));
      for (int b = 0; b < ((cfg_chunks == 5'd0) ? 1 : int'(cfg_chunks)); b++) begin
        rand_data();
        beat("rnd");
        if (b == 0) cfg_chunks = 5'($urandom_range(0, 31));
      end
    end
    drain_check("rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
